// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the core memory-port arbiter: bus widths, FSM state
// encodings and boolean constants.
package bus_arbiter_pkg;

  localparam int unsigned InstAddrBus = 32;  // address width of all buses
  localparam int unsigned InstBus     = 32;  // data width of all buses
  localparam int unsigned MemSelBus   = 4;   // byte-select width (InstBus/8)

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Arbiter FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IREQ  = 3'd1,
    ST_IWAIT = 3'd2,
    ST_DREQ  = 3'd3,
    ST_DWAIT = 3'd4
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates the single core memory port between instruction fetch (ibus)
// and load/store (dbus). Fixed priority: dbus first. One outstanding memory
// transaction at a time; read data is registered to the owning requester.
//
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   flush_i               pipeline flush (discards an in-flight fetch)
//   ibus_*                fetch request/address in, instruction + stall out
//   dbus_*                load/store request/fields in, load data + stall out
//   mem_valid_o/ready_i   request handshake toward memory
//   mem_we/sel/addr/wdata request payload toward memory
//   mem_rvalid_i/rdata_i  memory response (read data or write ack)
//
// A memory that never responds leaves the FSM waiting indefinitely.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = InstBus,
  parameter int unsigned SEL_W  = MemSelBus
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              ibus_req_i,
  input  logic [ADDR_W-1:0] ibus_addr_i,
  output logic [DATA_W-1:0] ibus_data_o,
  output logic              ibus_stallreq_o,
  input  logic              dbus_req_i,
  input  logic              dbus_we_i,
  input  logic [SEL_W-1:0]  dbus_sel_i,
  input  logic [ADDR_W-1:0] dbus_addr_i,
  input  logic [DATA_W-1:0] dbus_wdata_i,
  output logic [DATA_W-1:0] dbus_rdata_o,
  output logic              dbus_stallreq_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [SEL_W-1:0]  mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              w_cap_i;
  logic              w_cap_d;
  logic              w_ibus_wr;
  logic              w_dbus_wr;
  logic              w_discard_nxt;

  logic              r_discard;
  logic              r_idone;
  logic              r_ddone;
  logic              r_valid;
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ibus_data;
  logic [DATA_W-1:0] r_dbus_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, capture and response-routing decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_cap_i       = False;
    w_cap_d       = False;
    w_ibus_wr     = False;
    w_dbus_wr     = False;
    w_discard_nxt = r_discard;

    case (r_state)
      ST_IDLE: begin
        w_discard_nxt = False;
        // A requester whose done pulse is high still shows its just-served
        // request this cycle; re-granting it would issue a duplicate access.
        if (dbus_req_i && !r_ddone) begin
          w_cap_d     = True;
          w_state_nxt = ST_DREQ;
        end else if (ibus_req_i && !flush_i && !r_idone) begin
          w_cap_i     = True;
          w_state_nxt = ST_IREQ;
        end
      end
      ST_IREQ: begin
        if (flush_i) begin
          w_discard_nxt = True;
        end
        if (mem_ready_i) begin
          w_state_nxt = ST_IWAIT;
        end
      end
      ST_IWAIT: begin
        if (flush_i) begin
          w_discard_nxt = True;
        end
        if (mem_rvalid_i) begin
          // A flush arriving with the response also makes it stale
          w_ibus_wr     = !(r_discard || flush_i);
          w_discard_nxt = False;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_DREQ: begin
        if (mem_ready_i) begin
          w_state_nxt = ST_DWAIT;
        end
      end
      ST_DWAIT: begin
        if (mem_rvalid_i) begin
          w_dbus_wr   = True;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_discard_nxt = False;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // Request capture, response data, done pulses and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_discard    <= False;
      r_idone      <= False;
      r_ddone      <= False;
      r_valid      <= False;
      r_we         <= False;
      r_sel        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ibus_data  <= '0;
      r_dbus_rdata <= '0;
    end else begin
      r_discard <= w_discard_nxt;
      r_idone   <= w_ibus_wr;
      r_ddone   <= w_dbus_wr;
      r_valid   <= (w_state_nxt == ST_IREQ) || (w_state_nxt == ST_DREQ);
      if (w_cap_d) begin
        r_we    <= dbus_we_i;
        r_sel   <= dbus_sel_i;
        r_addr  <= dbus_addr_i;
        r_wdata <= dbus_wdata_i;
      end else if (w_cap_i) begin
        r_we    <= False;
        r_sel   <= {SEL_W{1'b1}};
        r_addr  <= ibus_addr_i;
        r_wdata <= '0;
      end
      if (w_ibus_wr) begin
        r_ibus_data <= mem_rdata_i;
      end
      if (w_dbus_wr) begin
        r_dbus_rdata <= mem_rdata_i;
      end
    end
  end

  assign mem_valid_o     = r_valid;
  assign mem_we_o        = r_we;
  assign mem_sel_o       = r_sel;
  assign mem_addr_o      = r_addr;
  assign mem_wdata_o     = r_wdata;
  assign ibus_data_o     = r_ibus_data;
  assign dbus_rdata_o    = r_dbus_rdata;
  assign ibus_stallreq_o = ibus_req_i & !r_idone;
  assign dbus_stallreq_o = dbus_req_i & !r_ddone;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by a
// randomized phase against a transaction-level requester/memory model.
module tb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        ibus_req_i;
  logic [31:0] ibus_addr_i;
  logic [31:0] ibus_data_o;
  logic        ibus_stallreq_o;
  logic        dbus_req_i;
  logic        dbus_we_i;
  logic [3:0]  dbus_sel_i;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_wdata_i;
  logic [31:0] dbus_rdata_o;
  logic        dbus_stallreq_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  bus_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .ibus_req_i     (ibus_req_i),
    .ibus_addr_i    (ibus_addr_i),
    .ibus_data_o    (ibus_data_o),
    .ibus_stallreq_o(ibus_stallreq_o),
    .dbus_req_i     (dbus_req_i),
    .dbus_we_i      (dbus_we_i),
    .dbus_sel_i     (dbus_sel_i),
    .dbus_addr_i    (dbus_addr_i),
    .dbus_wdata_i   (dbus_wdata_i),
    .dbus_rdata_o   (dbus_rdata_o),
    .dbus_stallreq_o(dbus_stallreq_o),
    .mem_valid_o    (mem_valid_o),
    .mem_ready_i    (mem_ready_i),
    .mem_we_o       (mem_we_o),
    .mem_sel_o      (mem_sel_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t log_q[$];

  // Memory model state
  int          ready_dly = 0;
  int          resp_dly  = 1;
  bit          rnd_mem   = 0;
  int          wait_cnt  = 0;
  bit          resp_pend = 0;
  int          resp_cnt  = 0;
  logic [31:0] resp_data = '0;

  // Requester agents for the random phase
  bit          rnd_chk = 0;
  bit          i_act = 0;
  logic [31:0] i_addr = '0;
  bit          d_act = 0;
  logic        d_we = 0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  int          i_served = 0;
  int          d_served = 0;
  int          i_txns = 0;
  int          d_txns = 0;
  logic [31:0] prev_data;
  txn_t        t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: fixed instruction at the reset vector, address hash elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    return a ^ 32'h1357_9BDF;
  endfunction

  // One cycle of memory behaviour, evaluated just after the clock edge
  task automatic mem_tick();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    if (resp_pend) begin
      if (resp_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = resp_data;
        resp_pend    = 0;
      end else begin
        resp_cnt--;
      end
    end
    if (mem_valid_o && !resp_pend && !mem_rvalid_i) begin
      if (wait_cnt >= ready_dly) begin
        mem_ready_i = 1'b1;
        wait_cnt    = 0;
        log_q.push_back('{we: mem_we_o, sel: mem_sel_o, addr: mem_addr_o, wdata: mem_wdata_o});
        resp_pend = 1;
        resp_cnt  = resp_dly - 1;
        resp_data = mem_we_o ? 32'h0 : mem_word(mem_addr_o);
        if (rnd_chk) begin
          if (mem_we_o || mem_addr_o[31:28] == 4'h9) begin
            d_txns++;
            chk("rnd_d_act", 32'(d_act), 32'd1);
            chk("rnd_d_addr", mem_addr_o, d_addr);
            chk("rnd_d_we", 32'(mem_we_o), 32'(d_we));
            chk("rnd_d_sel", 32'(mem_sel_o), 32'(d_sel));
            if (d_we) chk("rnd_d_wdata", mem_wdata_o, d_wdata);
          end else begin
            i_txns++;
            chk("rnd_i_act", 32'(i_act), 32'd1);
            chk("rnd_i_addr", mem_addr_o, i_addr);
            chk("rnd_i_sel", 32'(mem_sel_o), 32'hF);
          end
        end
        if (rnd_mem) begin
          ready_dly = $urandom_range(0, 2);
          resp_dly  = $urandom_range(1, 3);
        end
      end else begin
        wait_cnt++;
      end
    end
  endtask

  // Advance to the next cycle; inputs may be driven on return
  task automatic cyc();
    @(posedge clk);
    #1;
    mem_tick();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic mem_reset();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    wait_cnt     = 0;
    resp_pend    = 0;
    resp_cnt     = 0;
  endtask

  initial begin
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    ibus_req_i   = 1'b0;
    ibus_addr_i  = '0;
    dbus_req_i   = 1'b0;
    dbus_we_i    = 1'b0;
    dbus_sel_i   = '0;
    dbus_addr_i  = '0;
    dbus_wdata_i = '0;
    mem_reset();

    // Reset state
    #13;
    chk("rst_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_idata", ibus_data_o, 32'd0);
    chk("rst_drdata", dbus_rdata_o, 32'd0);
    chk("rst_istall", 32'(ibus_stallreq_o), 32'd0);
    #9 rst_n = 1'b1;

    // Single fetch, minimum latency
    cyc(); ibus_req_i = 1'b1; ibus_addr_i = 32'h8000_0000; settle();
    chk("t1_c0_stall", 32'(ibus_stallreq_o), 32'd1);
    chk("t1_c0_valid", 32'(mem_valid_o), 32'd0);
    cyc(); settle();
    chk("t1_c1_valid", 32'(mem_valid_o), 32'd1);
    chk("t1_c1_addr", mem_addr_o, 32'h8000_0000);
    chk("t1_c1_we", 32'(mem_we_o), 32'd0);
    chk("t1_c1_sel", 32'(mem_sel_o), 32'hF);
    chk("t1_c1_stall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t1_c2_valid", 32'(mem_valid_o), 32'd0);
    chk("t1_c2_stall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t1_c3_data", ibus_data_o, 32'h0000_0013);
    chk("t1_c3_stall", 32'(ibus_stallreq_o), 32'd0);
    chk("t1_c3_valid", 32'(mem_valid_o), 32'd0);
    cyc(); ibus_req_i = 1'b0; settle();
    chk("t1_c4_valid", 32'(mem_valid_o), 32'd0);
    chk("t1_ntxn", 32'(log_q.size()), 32'd1);

    // Simultaneous fetch and load: load goes first
    log_q.delete();
    cyc();
    ibus_req_i = 1'b1; ibus_addr_i = 32'h8000_0004;
    dbus_req_i = 1'b1; dbus_we_i = 1'b0; dbus_sel_i = 4'hF; dbus_addr_i = 32'h8000_1000;
    settle();
    chk("t2_c0_istall", 32'(ibus_stallreq_o), 32'd1);
    chk("t2_c0_dstall", 32'(dbus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t2_c1_addr", mem_addr_o, 32'h8000_1000);
    chk("t2_c1_valid", 32'(mem_valid_o), 32'd1);
    chk("t2_c1_istall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t2_c2_istall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t2_c3_drdata", dbus_rdata_o, mem_word(32'h8000_1000));
    chk("t2_c3_dstall", 32'(dbus_stallreq_o), 32'd0);
    chk("t2_c3_valid", 32'(mem_valid_o), 32'd0);
    chk("t2_c3_istall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); dbus_req_i = 1'b0; settle();
    chk("t2_c4_valid", 32'(mem_valid_o), 32'd1);
    chk("t2_c4_addr", mem_addr_o, 32'h8000_0004);
    chk("t2_c4_istall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t2_c5_istall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t2_c6_idata", ibus_data_o, mem_word(32'h8000_0004));
    chk("t2_c6_istall", 32'(ibus_stallreq_o), 32'd0);
    cyc(); ibus_req_i = 1'b0; settle();
    chk("t2_ntxn", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t2_first", log_q[0].addr, 32'h8000_1000);
      chk("t2_second", log_q[1].addr, 32'h8000_0004);
    end

    // Store under backpressure: ready low for 4 cycles
    ready_dly = 4;
    cyc();
    dbus_req_i = 1'b1; dbus_we_i = 1'b1; dbus_sel_i = 4'b0011;
    dbus_addr_i = 32'h8000_2000; dbus_wdata_i = 32'hDEAD_BEEF;
    settle();
    for (int k = 1; k <= 5; k++) begin
      cyc(); settle();
      chk($sformatf("t3_c%0d_valid", k), 32'(mem_valid_o), 32'd1);
      chk($sformatf("t3_c%0d_addr", k), mem_addr_o, 32'h8000_2000);
      chk($sformatf("t3_c%0d_we", k), 32'(mem_we_o), 32'd1);
      chk($sformatf("t3_c%0d_sel", k), 32'(mem_sel_o), 32'h3);
      chk($sformatf("t3_c%0d_wdata", k), mem_wdata_o, 32'hDEAD_BEEF);
      chk($sformatf("t3_c%0d_ready", k), 32'(mem_ready_i), (k == 5) ? 32'd1 : 32'd0);
    end
    cyc(); settle();
    chk("t3_c6_valid", 32'(mem_valid_o), 32'd0);
    chk("t3_c6_dstall", 32'(dbus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t3_c7_dstall", 32'(dbus_stallreq_o), 32'd0);
    cyc(); dbus_req_i = 1'b0; dbus_we_i = 1'b0; ready_dly = 0; settle();

    // Flush during IWAIT: response dropped, redirected fetch served
    prev_data = ibus_data_o;
    resp_dly  = 3;
    cyc(); ibus_req_i = 1'b1; ibus_addr_i = 32'h8000_0008; settle();
    cyc(); settle();
    chk("t4_c1_addr", mem_addr_o, 32'h8000_0008);
    cyc(); flush_i = 1'b1; ibus_addr_i = 32'h8000_0100; settle();
    cyc(); flush_i = 1'b0; settle();
    chk("t4_c3_stall", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t4_c4_rvalid", 32'(mem_rvalid_i), 32'd1);
    cyc(); resp_dly = 1; settle();
    chk("t4_c5_data_kept", ibus_data_o, prev_data);
    chk("t4_c5_no_done", 32'(ibus_stallreq_o), 32'd1);
    cyc(); settle();
    chk("t4_c6_valid", 32'(mem_valid_o), 32'd1);
    chk("t4_c6_addr", mem_addr_o, 32'h8000_0100);
    cyc(); settle();
    cyc(); settle();
    chk("t4_c8_data", ibus_data_o, mem_word(32'h8000_0100));
    chk("t4_c8_stall", 32'(ibus_stallreq_o), 32'd0);
    cyc(); ibus_req_i = 1'b0; settle();

    // Reset asserted in DWAIT
    resp_dly = 3;
    cyc(); dbus_req_i = 1'b1; dbus_we_i = 1'b0; dbus_sel_i = 4'hF; dbus_addr_i = 32'h8000_3000; settle();
    cyc(); settle();
    cyc(); settle();
    chk("t5_dwait_stall", 32'(dbus_stallreq_o), 32'd1);
    rst_n = 1'b0; dbus_req_i = 1'b0;
    mem_reset();
    resp_dly = 1;
    settle();
    chk("t5_rst_valid", 32'(mem_valid_o), 32'd0);
    chk("t5_rst_addr", mem_addr_o, 32'd0);
    chk("t5_rst_sel", 32'(mem_sel_o), 32'd0);
    chk("t5_rst_idata", ibus_data_o, 32'd0);
    chk("t5_rst_drdata", dbus_rdata_o, 32'd0);
    chk("t5_rst_dstall", 32'(dbus_stallreq_o), 32'd0);
    #2 rst_n = 1'b1;
    cyc(); ibus_req_i = 1'b1; ibus_addr_i = 32'h8000_0200; settle();
    cyc(); settle();
    chk("t5_c1_valid", 32'(mem_valid_o), 32'd1);
    chk("t5_c1_addr", mem_addr_o, 32'h8000_0200);
    cyc(); settle();
    cyc(); settle();
    chk("t5_c3_data", ibus_data_o, mem_word(32'h8000_0200));
    chk("t5_c3_stall", 32'(ibus_stallreq_o), 32'd0);
    cyc(); ibus_req_i = 1'b0; settle();

    // Random traffic against the requester/memory model
    rnd_mem = 1; rnd_chk = 1;
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (c < 1200) begin
        if (!i_act && ($urandom_range(0, 3) == 0)) begin
          i_act  = 1;
          i_addr = {20'h80000, 10'($urandom_range(0, 1023)), 2'b00};
        end
        if (!d_act && ($urandom_range(0, 3) == 0)) begin
          d_act   = 1;
          d_we    = 1'($urandom_range(0, 1));
          d_sel   = 4'($urandom_range(1, 15));
          d_addr  = {20'h90000, 10'($urandom_range(0, 1023)), 2'b00};
          d_wdata = $urandom;
        end
      end
      ibus_req_i = i_act; ibus_addr_i = i_addr;
      dbus_req_i = d_act; dbus_we_i = d_we; dbus_sel_i = d_sel;
      dbus_addr_i = d_addr; dbus_wdata_i = d_wdata;
      settle();
      if (i_act && !ibus_stallreq_o) begin
        chk("rnd_idata", ibus_data_o, mem_word(i_addr));
        i_served++;
        i_act = 0;
      end
      if (d_act && !dbus_stallreq_o) begin
        if (!d_we) chk("rnd_drdata", dbus_rdata_o, mem_word(d_addr));
        d_served++;
        d_act = 0;
      end
    end
    chk("rnd_i_drained", 32'(i_act), 32'd0);
    chk("rnd_d_drained", 32'(d_act), 32'd0);
    chk("rnd_i_once", 32'(i_txns), 32'(i_served));
    chk("rnd_d_once", 32'(d_txns), 32'(d_served));
    chk("rnd_some_traffic", 32'(i_served > 20 && d_served > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single core memory port between the instruction fetch bus (ifu) and the data bus (lsu).
- Runs a request/response FSM toward memory and returns read data to the granted requester.
- Raises per-requester stall requests to pipe_ctrl while a request is outstanding.
- Sits between the core and the memory or peripheral interconnect; it is the only master on that port.

Parameters:
- ADDR_W, 32, address width of all buses.
- DATA_W, 32, data width of all buses.
- SEL_W, 4, byte-select width (DATA_W/8).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush from pipe_ctrl
- ibus_req_i  in  1  fetch request (level)
- ibus_addr_i  in  ADDR_W  fetch address
- ibus_data_o  out  DATA_W  fetched instruction
- ibus_stallreq_o  out  1  fetch not yet served
- dbus_req_i  in  1  load/store request (level)
- dbus_we_i  in  1  1 = store
- dbus_sel_i  in  SEL_W  byte enables
- dbus_addr_i  in  ADDR_W  data address
- dbus_wdata_i  in  DATA_W  store data
- dbus_rdata_o  out  DATA_W  load data
- dbus_stallreq_o  out  1  data access not yet served
- mem_valid_o  out  1  request valid toward memory
- mem_ready_i  in  1  memory accepts request
- mem_we_o  out  1  write enable
- mem_sel_o  out  SEL_W  byte enables
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  write data
- mem_rvalid_i  in  1  response valid (read data, or write ack)
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; all outputs 0; discard flag 0; captured request registers 0.
- FSM states are IDLE, IREQ, IWAIT, DREQ, DWAIT.
- IDLE:
  - If dbus_req_i, capture the dbus fields and go to DREQ.
  - Else if ibus_req_i and !flush_i, capture ibus_addr_i and go to IREQ.
  - Fixed priority: dbus beats ibus, because the data access belongs to the older instruction.
- IREQ/DREQ:
  - mem_valid_o=1; mem_* driven from the captured registers and held stable until mem_ready_i.
  - A fetch drives we=0 and sel=all-ones.
  - On mem_ready_i, go to IWAIT/DWAIT. Valid is never withdrawn before ready.
- IWAIT/DWAIT:
  - mem_valid_o=0. On mem_rvalid_i, register mem_rdata_i into ibus_data_o or dbus_rdata_o, then go to IDLE.
  - Response in the same cycle as ready is illegal; minimum response is one cycle after ready.
- Minimum latency is 3 cycles: request seen in IDLE (c0), valid+ready (c1), rvalid (c2). Data is visible on *_data_o from c3.
- Stall requests:
  - ibus_stallreq_o = ibus_req_i & !ifetch_done.
  - dbus_stallreq_o = dbus_req_i & !daccess_done.
  - *_done is a one-cycle registered pulse, asserted the cycle after rvalid, for the owner (and, for ibus, only when not discarded).
  - In the done cycle the stall is low and *_data_o is valid, so the pipeline advances exactly once per served request.
- Data outputs hold their last value until the next response for the same requester.
- Flush:
  - flush_i in IREQ/IWAIT sets the discard flag. The bus transaction still completes.
  - The discarded response is not written to ibus_data_o, and no ifetch_done is produced.
  - The discard flag clears on entering IDLE.
  - flush_i in IDLE blocks a new fetch for that cycle only.
  - flush_i never affects dbus transactions.
- Simultaneous events:
  - dbus and ibus requests in the same IDLE cycle: dbus is served first, ibus stays stalled.
  - A request arriving during a busy state waits; nothing is queued beyond the level request.
- No timeout: a memory that never responds hangs the FSM (documented; not handled).
- Reset mid-transaction: immediate return to IDLE with outputs 0. The memory side is reset by the same rst_n.

Decomposition:
- The shared defines package holds the bus widths (InstAddrBus, InstBus, MemSelBus), the FSM state encodings (3-bit, localparam-style constants) and True/False.
- No sub-module: a single FSM with capture registers (~200 lines).

Test Plan:
- Single fetch at 0x8000_0000, memory ready immediately, rvalid 1 cycle later with 0x0000_0013:
  - mem_valid_o high for exactly 1 cycle.
  - ibus_data_o=0x13 and ibus_stallreq_o low in c3; stall high c0–c2.
- Simultaneous ibus (0x8000_0004) and dbus load (0x8000_1000):
  - Memory sees 0x8000_1000 first.
  - dbus_rdata_o is updated before the fetch is issued.
  - ibus_stallreq_o stays high throughout.
- Backpressure with mem_ready_i low for 4 cycles:
  - mem_addr_o, mem_we_o, mem_sel_o and mem_wdata_o are constant and mem_valid_o high for all 5 cycles.
  - Store sel=4'b0011 and wdata=0xDEAD_BEEF appear unchanged.
- flush_i during IWAIT for fetch 0x8000_0008:
  - ibus_data_o keeps its previous value; no done pulse.
  - The next fetch (flush target 0x8000_0100) is issued and served normally.
- Reset asserted in DWAIT:
  - All outputs 0 asynchronously; FSM in IDLE.
  - After release, a new fetch completes with 3-cycle latency.
